// File: rtl/spi_minion_pkg.sv
// Shared types and frame-field positions for the SPI mode-0 minion shifter.
// Field positions are counted down from the frame MSB so they hold for any nbits.
package spi_minion_pkg;

    typedef enum logic [1:0] {
        RESYNC = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2
    } spi_minion_state_t;

    // Frame layout: [nbits-1]=val, [nbits-2]=spc, [nbits-3:0]=data.
    localparam int unsigned VAL_FROM_TOP = 1;
    localparam int unsigned SPC_FROM_TOP = 2;
    localparam int unsigned HDR_BITS     = 2;

endpackage

// File: rtl/spi_minion_sync.sv
// Multi-flop synchronizer with a history flop for edge detection.
// Ports: clk, reset (sync, active-high), din (async) -> q (synced), rise, fall.
module spi_minion_sync #(
    parameter int unsigned sync_depth = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [sync_depth-1:0] chain;
    logic                  hist;

    // Cleared to 0 so a cs held low through reset is never seen high.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
            hist  <= 1'b0;
        end else begin
            chain <= {chain[sync_depth-2:0], din};
            hist  <= chain[sync_depth-1];
        end
    end

    assign q    = chain[sync_depth-1];
    assign rise = q & ~hist;
    assign fall = ~q & hist;

endmodule

// File: rtl/spi_minion_shifter.sv
// SPI mode-0 minion front end: oversamples cs/sclk/mosi, shifts one nbits frame
// MSB-first in on mosi / out on miso, and issues one pull and one push per cs-low window.
// Ports: clk, reset (sync, active-high); SPI cs/sclk/mosi in, miso out;
//   push_en + push_msg_{val_wrt,val_rd,data} out; pull_en out, pull_msg_{val,spc,data} in.
// Option SPI_MINION_FRAME_ERR_EN adds frame_err pulse and 8-bit saturating frame_err_cnt.
module spi_minion_shifter
    import spi_minion_pkg::*;
#(
    parameter int unsigned nbits      = 8,
    parameter int unsigned sync_depth = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             sclk,
    input  logic             mosi,
    output logic             miso,
    output logic             push_en,
    output logic             push_msg_val_wrt,
    output logic             push_msg_val_rd,
    output logic [nbits-3:0] push_msg_data,
    output logic             pull_en,
    input  logic             pull_msg_val,
    input  logic             pull_msg_spc,
    input  logic [nbits-3:0] pull_msg_data
`ifdef SPI_MINION_FRAME_ERR_EN
    ,
    output logic             frame_err,
    output logic [7:0]       frame_err_cnt
`endif
);

    localparam int unsigned CW = $clog2(nbits + 1);

    spi_minion_state_t state, state_next;

    logic cs_q, cs_rise, cs_fall;
    logic sclk_q, sclk_rise, sclk_fall;
    logic mosi_q, mosi_rise, mosi_fall;

    logic             load;
    logic [CW-1:0]    bit_cnt;
    logic [nbits-1:0] shreg;
    logic             full;
    logic             push_fire;
    logic             frame_drop;

    spi_minion_sync #(.sync_depth(sync_depth)) u_cs (
        .clk(clk), .reset(reset), .din(cs),
        .q(cs_q), .rise(cs_rise), .fall(cs_fall)
    );

    spi_minion_sync #(.sync_depth(sync_depth)) u_sclk (
        .clk(clk), .reset(reset), .din(sclk),
        .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_minion_sync #(.sync_depth(sync_depth)) u_mosi (
        .clk(clk), .reset(reset), .din(mosi),
        .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
    );

    logic unused_sig;
    assign unused_sig = ^{sclk_q, mosi_rise, mosi_fall};

    assign full = (bit_cnt == CW'(nbits));

    always_ff @(posedge clk) begin
        if (reset) state <= RESYNC;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            RESYNC: if (cs_q)    state_next = IDLE;
            IDLE:   if (cs_fall) state_next = ACTIVE;
            ACTIVE: if (cs_rise) state_next = IDLE;
            default:             state_next = RESYNC;
        endcase
    end

    always_comb begin
        pull_en    = 1'b0;
        push_fire  = 1'b0;
        frame_drop = 1'b0;
        unique case (state)
            IDLE:   pull_en    = cs_fall;
            ACTIVE: begin
                push_fire  = cs_rise & full;
                frame_drop = cs_rise & ~full;
            end
            default: ;
        endcase
    end

    // load marks the first ACTIVE cycle, when the adapter's pull_msg is captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            load             <= 1'b0;
            bit_cnt          <= '0;
            shreg            <= '0;
            miso             <= 1'b0;
            push_en          <= 1'b0;
            push_msg_val_wrt <= 1'b0;
            push_msg_val_rd  <= 1'b0;
            push_msg_data    <= '0;
        end else begin
            load    <= pull_en;
            push_en <= push_fire;
            if (push_fire) begin
                push_msg_val_wrt <= shreg[nbits-VAL_FROM_TOP];
                push_msg_val_rd  <= shreg[nbits-SPC_FROM_TOP];
                push_msg_data    <= shreg[nbits-HDR_BITS-1:0];
            end
            if (state == ACTIVE && state_next == ACTIVE) begin
                if (load) begin
                    shreg   <= {pull_msg_val, pull_msg_spc, pull_msg_data};
                    bit_cnt <= '0;
                    miso    <= pull_msg_val;
                end else begin
                    if (sclk_rise) begin
                        shreg <= {shreg[nbits-2:0], mosi_q};
                        if (!full) bit_cnt <= bit_cnt + CW'(1);
                    end
                    if (sclk_fall) miso <= shreg[nbits-1];
                end
            end else begin
                miso <= 1'b0;
            end
        end
    end

`ifdef SPI_MINION_FRAME_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err     <= 1'b0;
            frame_err_cnt <= '0;
        end else begin
            frame_err <= frame_drop;
            if (frame_drop && frame_err_cnt != 8'hFF)
                frame_err_cnt <= frame_err_cnt + 8'd1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = frame_drop;
`endif

endmodule

// File: tb/tb_spi_minion_shifter.sv
// Self-checking bench for spi_minion_shifter (nbits=8): frame-level model with
// expected-push queue, pull counting and per-bit miso expectations.
module tb_spi_minion_shifter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs, sclk, mosi, miso;
    logic       push_en, push_msg_val_wrt, push_msg_val_rd;
    logic [5:0] push_msg_data;
    logic       pull_en, pull_msg_val, pull_msg_spc;
    logic [5:0] pull_msg_data;
`ifdef SPI_MINION_FRAME_ERR_EN
    logic       frame_err;
    logic [7:0] frame_err_cnt;
`endif

    spi_minion_shifter #(.nbits(8), .sync_depth(2)) dut (
        .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi),
        .miso(miso), .push_en(push_en),
        .push_msg_val_wrt(push_msg_val_wrt), .push_msg_val_rd(push_msg_val_rd),
        .push_msg_data(push_msg_data), .pull_en(pull_en),
        .pull_msg_val(pull_msg_val), .pull_msg_spc(pull_msg_spc),
        .pull_msg_data(pull_msg_data)
`ifdef SPI_MINION_FRAME_ERR_EN
        , .frame_err(frame_err), .frame_err_cnt(frame_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_push = 8'h00;
    int pull_seen = 0, exp_pull = 0, push_seen = 0;
    int err_seen = 0, exp_err = 0;
    bit armed = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (!reset) begin
            if (pull_en) begin
                pull_seen++;
                check("pull_push_overlap", {31'd0, push_en}, 0);
            end
            if (push_en) begin
                push_seen++;
                if (exp_q.size() == 0) check("unexpected_push", 1, 0);
                else last_push = exp_q.pop_front();
            end
            check("push_msg", {24'd0, push_msg_val_wrt, push_msg_val_rd, push_msg_data},
                  {24'd0, last_push});
`ifdef SPI_MINION_FRAME_ERR_EN
            if (frame_err) err_seen++;
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        last_push = 8'h00;
        exp_q.delete();
        armed = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    // n sclk pulses (n<=8); reset pulse before bit kill_at if kill_at>=0.
    task automatic frame(input logic [7:0] tx, input logic [7:0] rx, input int n,
                         input int kill_at, input int gap, output logic [7:0] mb);
        bit killed;
        bit was_armed;
        killed = 1'b0;
        was_armed = armed;
        {pull_msg_val, pull_msg_spc, pull_msg_data} = tx;
        cs = 1'b0;
        if (was_armed) exp_pull++;
        tick(8);
        check("pull_count", pull_seen, exp_pull);
        mb = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (i == kill_at) begin
                do_reset();
                killed = 1'b1;
            end
            mosi = rx[7-i];
            tick(5);
            mb[7-i] = miso;
            check("miso_bit", {31'd0, miso}, killed ? 0 : {31'd0, tx[7-i]});
            sclk = 1'b1;
            tick(5);
            sclk = 1'b0;
        end
        tick(5);
        cs = 1'b1;
        if (!killed && was_armed) begin
            if (n == 8) exp_q.push_back(rx);
            else exp_err++;
        end
        tick(gap);
        armed = 1'b1;
        if (gap >= 6) begin
            check("push_drained", exp_q.size(), 0);
            check("miso_idle", {31'd0, miso}, 0);
        end
    endtask

    logic [7:0] mb;
    int p0, q0;

    initial begin
        reset = 1'b0;
        cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        {pull_msg_val, pull_msg_spc, pull_msg_data} = 8'h00;
        tick(1);
        do_reset();
        check("rst_miso", {31'd0, miso}, 0);
        check("rst_push_en", {31'd0, push_en}, 0);
        check("rst_pull_en", {31'd0, pull_en}, 0);
        check("rst_msg", {24'd0, push_msg_val_wrt, push_msg_val_rd, push_msg_data}, 0);
        tick(6);
        armed = 1'b1;

        // Full receive frame A5.
        frame(8'h00, 8'hA5, 8, -1, 8, mb);
        check("a5_val_wrt", {31'd0, push_msg_val_wrt}, 1);
        check("a5_val_rd", {31'd0, push_msg_val_rd}, 0);
        check("a5_data", {26'd0, push_msg_data}, 32'h25);

        // Transmit BC (val=1, spc=0, data=3C).
        frame(8'hBC, 8'h3C, 8, -1, 8, mb);
        check("tx_bc", {24'd0, mb}, 32'hBC);

        // Short frame leaves push_msg holding 3C.
        p0 = push_seen;
        frame(8'h55, 8'hFF, 5, -1, 8, mb);
        check("short_no_push", push_seen, p0);
        check("short_hold", {24'd0, push_msg_val_wrt, push_msg_val_rd, push_msg_data},
              32'h3C);
`ifdef SPI_MINION_FRAME_ERR_EN
        check("short_err_cnt", {24'd0, frame_err_cnt}, 1);
`endif

        // Reset after 3 bits with cs low, 5 more bits, then a clean 81.
        p0 = push_seen;
        frame(8'h12, 8'hF0, 8, 3, 8, mb);
        check("kill_no_push", push_seen, p0);
        frame(8'h00, 8'h81, 8, -1, 8, mb);
        check("r81_val_wrt", {31'd0, push_msg_val_wrt}, 1);
        check("r81_data", {26'd0, push_msg_data}, 32'h01);

        // Back-to-back FF then 00 with a 2-clk cs-high gap.
        p0 = push_seen;
        q0 = pull_seen;
        frame(8'hC3, 8'hFF, 8, -1, 2, mb);
        frame(8'h3C, 8'h00, 8, -1, 8, mb);
        check("b2b_pushes", push_seen - p0, 2);
        check("b2b_pulls", pull_seen - q0, 2);
        check("b2b_last", {24'd0, push_msg_val_wrt, push_msg_val_rd, push_msg_data}, 0);

        // sclk activity with cs high.
        p0 = push_seen;
        q0 = pull_seen;
        for (int i = 0; i < 6; i++) begin
            mosi = 1'($urandom);
            sclk = 1'b1; tick(5);
            check("cs_high_miso", {31'd0, miso}, 0);
            sclk = 1'b0; tick(5);
        end
        check("cs_high_push", push_seen, p0);
        check("cs_high_pull", pull_seen, q0);

        // Randomized frames.
        for (int k = 0; k < 20; k++) begin
            logic [7:0] tx, rx;
            int n;
            tx = 8'($urandom);
            rx = 8'($urandom);
            n = ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 0)) : 8;
            frame(tx, rx, n, -1, int'($urandom_range(12, 6)), mb);
            if (n == 8) check("rand_tx", {24'd0, mb}, {24'd0, tx});
        end

        tick(10);
        check("final_drained", exp_q.size(), 0);
        check("final_pulls", pull_seen, exp_pull);
`ifdef SPI_MINION_FRAME_ERR_EN
        check("final_err_pulses", err_seen, exp_err);
        check("final_err_cnt", {24'd0, frame_err_cnt}, exp_err);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
